// File: rtl/transmitter_ok_if.sv
// transmitter_ok_if: request/response bundle for the status-string UART transmitter.
//   send_ok  : request "OK\r\n"            (master -> slave)
//   send_err : request "ERROR\r\n"         (master -> slave)
//   txd      : UART serial line, idles high (slave -> master)
//   busy     : message in progress         (slave -> master)
//   SEND_END : one-cycle end-of-message    (slave -> master)
interface transmitter_ok_if;
  logic send_ok;
  logic send_err;
  logic txd;
  logic busy;
  logic SEND_END;

  modport master (
    output send_ok,
    output send_err,
    input  txd,
    input  busy,
    input  SEND_END
  );

  modport slave (
    input  send_ok,
    input  send_err,
    output txd,
    output busy,
    output SEND_END
  );
endinterface

// File: rtl/transmitter_ok.sv
// transmitter_ok: sends "OK\r\n" or "ERROR\r\n" as contiguous 8N1 UART frames on one request.
//   iCLK : system clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : transmitter_ok_if.slave (send_ok, send_err in; txd, busy, SEND_END out)
// CLK_DIV is the number of iCLK cycles per UART bit (minimum 2).
module transmitter_ok #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic             iCLK,
  input  logic             RST,
  transmitter_ok_if.slave  bus
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state;
  logic [CntW-1:0] baud_cnt;
  logic [2:0]      bit_idx;
  logic [2:0]      byte_idx;
  logic            msg_err;
  logic [7:0]      shift;

  logic       bit_done;
  logic [2:0] last_idx;

  assign bit_done = (baud_cnt == CntMax);
  assign last_idx = msg_err ? 3'd6 : 3'd3;

  // Message ROM: {err, idx} -> byte.
  function automatic logic [7:0] msg_byte(input logic err, input logic [2:0] idx);
    logic [7:0] b;
    case ({err, idx})
      4'b0_000: b = 8'h4F;
      4'b0_001: b = 8'h4B;
      4'b0_010: b = 8'h0D;
      4'b0_011: b = 8'h0A;
      4'b1_000: b = 8'h45;
      4'b1_001: b = 8'h52;
      4'b1_010: b = 8'h52;
      4'b1_011: b = 8'h4F;
      4'b1_100: b = 8'h52;
      4'b1_101: b = 8'h0D;
      4'b1_110: b = 8'h0A;
      default:  b = 8'hFF;
    endcase
    return b;
  endfunction

  always_ff @(posedge iCLK) begin
    bus.SEND_END <= 1'b0;
    if (RST) begin
      state    <= StIdle;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      msg_err  <= 1'b0;
      shift    <= '0;
      bus.txd  <= 1'b1;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.send_ok || bus.send_err) begin
            // OK wins when both requests arrive together.
            msg_err  <= ~bus.send_ok;
            shift    <= msg_byte(~bus.send_ok, 3'd0);
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            bus.txd  <= 1'b0;
            bus.busy <= 1'b1;
            state    <= StStart;
          end
        end

        StStart: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bus.txd  <= shift[0];
            shift    <= shift >> 1;
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + CntW'(1);
          end
        end

        StData: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              bus.txd <= 1'b1;
              state   <= StStop;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              bus.txd <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + CntW'(1);
          end
        end

        StStop: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (byte_idx < last_idx) begin
              // Next frame starts immediately: no idle gap inside a message.
              byte_idx <= byte_idx + 3'd1;
              shift    <= msg_byte(msg_err, byte_idx + 3'd1);
              bus.txd  <= 1'b0;
              state    <= StStart;
            end else begin
              bus.txd      <= 1'b1;
              bus.busy     <= 1'b0;
              bus.SEND_END <= 1'b1;
              state        <= StIdle;
            end
          end else begin
            baud_cnt <= baud_cnt + CntW'(1);
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter_ok.sv
module tb_transmitter_ok;

  localparam int unsigned CLK_DIV = 4;
  localparam int          Bit     = CLK_DIV;
  localparam int          Half    = CLK_DIV / 2;

  logic iCLK;
  logic RST;
  transmitter_ok_if bus();

  transmitter_ok #(.CLK_DIV(CLK_DIV)) dut (
    .iCLK (iCLK),
    .RST  (RST),
    .bus  (bus)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         se_q[$];
  int         busy_q[$];

  logic [7:0] ok_msg  [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
  logic [7:0] err_msg [7] = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0D, 8'h0A};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_msg(input bit err);
    if (err) foreach (err_msg[i]) exp_q.push_back(err_msg[i]);
    else     foreach (ok_msg[i])  exp_q.push_back(ok_msg[i]);
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    se_q.delete();
    busy_q.delete();
  endtask

  task automatic wait_ends(input int n, input int limit);
    while (se_q.size() < n && cyc < limit) step();
    if (se_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL send_end_timeout: got %0d pulses expected %0d", se_q.size(), n);
    end
  endtask

  // Reference UART decoder sampling mid-bit, plus busy / SEND_END logging.
  logic       dec_active = 1'b0;
  int         dec_cnt    = 0;
  logic [7:0] dec_byte   = '0;
  logic       prev_txd   = 1'b1;
  logic       prev_busy  = 1'b0;
  int         busy_run   = 0;

  always @(negedge iCLK) begin
    if (RST) begin
      dec_active = 1'b0;
      prev_txd   = 1'b1;
    end else begin
      if (dec_active) begin
        dec_cnt++;
        if (dec_cnt == Half) begin
          chk("start_bit", bus.txd, 1'b0);
        end else if (dec_cnt > Half && dec_cnt < Half + 9 * Bit && (dec_cnt - Half) % Bit == 0) begin
          dec_byte[(dec_cnt - Half) / Bit - 1] = bus.txd;
        end else if (dec_cnt == Half + 9 * Bit) begin
          chk("stop_bit", bus.txd, 1'b1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %02h expected no frame", dec_byte);
          end else begin
            chk("rx_byte", dec_byte, exp_q.pop_front());
          end
          dec_active = 1'b0;
        end
      end else if (prev_txd === 1'b1 && bus.txd === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
      prev_txd = bus.txd;
    end

    if (bus.busy === 1'b1) begin
      busy_run++;
    end else if (prev_busy === 1'b1) begin
      busy_q.push_back(busy_run);
      busy_run = 0;
    end
    prev_busy = bus.busy;

    if (bus.SEND_END === 1'b1) begin
      se_q.push_back(cyc);
      chk("end_txd", bus.txd, 1'b1);
      chk("end_busy", bus.busy, 1'b0);
    end
  end

  typedef struct {
    bit ok;
    bit err;
    bit late_err;
    int exp_end;
    int exp_busy;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int acc;

    vecs[0] = '{ok: 1'b1, err: 1'b0, late_err: 1'b0, exp_end: 160, exp_busy: 160};
    vecs[1] = '{ok: 1'b0, err: 1'b1, late_err: 1'b0, exp_end: 280, exp_busy: 280};
    vecs[2] = '{ok: 1'b1, err: 1'b1, late_err: 1'b1, exp_end: 160, exp_busy: 160};

    // Reset held with a pending request.
    RST          = 1'b1;
    bus.send_ok  = 1'b1;
    bus.send_err = 1'b0;
    @(posedge iCLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      chk("rst_txd", bus.txd, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_send_end", bus.SEND_END, 1'b0);
      @(posedge iCLK);
    end
    #1;
    RST         = 1'b0;
    bus.send_ok = 1'b0;
    repeat (5) step();
    chk("post_rst_txd", bus.txd, 1'b1);
    chk("post_rst_busy", bus.busy, 1'b0);
    clear_logs();

    // Single requests and arbitration / ignore.
    for (int v = 0; v < 3; v++) begin
      clear_logs();
      push_msg(!vecs[v].ok);
      bus.send_ok  = vecs[v].ok;
      bus.send_err = vecs[v].err;
      acc = cyc;
      step();
      bus.send_ok  = 1'b0;
      bus.send_err = 1'b0;
      if (vecs[v].late_err) begin
        while (cyc < acc + 50) step();
        bus.send_err = 1'b1;
        step();
        bus.send_err = 1'b0;
      end
      wait_ends(1, acc + 600);
      repeat (60) step();
      chk("vec_end_count", se_q.size(), 1);
      chk("vec_end_cycle", (se_q.size() > 0) ? se_q[0] - acc - 1 : -1, vecs[v].exp_end);
      chk("vec_busy_runs", busy_q.size(), 1);
      chk("vec_busy_len", (busy_q.size() > 0) ? busy_q[0] : -1, vecs[v].exp_busy);
      chk("vec_bytes_left", exp_q.size(), 0);
    end

    // Reset mid-message, then a fresh request.
    clear_logs();
    exp_q.push_back(8'h4F);  // only the first frame completes before reset
    bus.send_ok = 1'b1;
    acc = cyc;
    step();
    bus.send_ok = 1'b0;
    while (cyc < acc + 50) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge iCLK);
    chk("abort_txd", bus.txd, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_send_end", bus.SEND_END, 1'b0);
    while (cyc < acc + 60) step();
    chk("abort_end_count", se_q.size(), 0);
    chk("abort_bytes_left", exp_q.size(), 0);
    clear_logs();
    push_msg(1'b0);
    bus.send_ok = 1'b1;
    acc = cyc;
    step();
    bus.send_ok = 1'b0;
    wait_ends(1, acc + 400);
    repeat (60) step();
    chk("rerun_end_count", se_q.size(), 1);
    chk("rerun_end_cycle", (se_q.size() > 0) ? se_q[0] - acc - 1 : -1, 160);
    chk("rerun_bytes_left", exp_q.size(), 0);

    // Back-to-back with send_ok held high.
    clear_logs();
    push_msg(1'b0);
    push_msg(1'b0);
    bus.send_ok = 1'b1;
    acc = cyc;
    while (cyc < acc + 200) step();
    bus.send_ok = 1'b0;
    wait_ends(2, acc + 800);
    repeat (60) step();
    chk("b2b_end_count", se_q.size(), 2);
    chk("b2b_end0", (se_q.size() > 0) ? se_q[0] - acc - 1 : -1, 160);
    chk("b2b_end1", (se_q.size() > 1) ? se_q[1] - acc - 1 : -1, 321);
    chk("b2b_busy_runs", busy_q.size(), 2);
    chk("b2b_busy1", (busy_q.size() > 1) ? busy_q[1] : -1, 160);
    chk("b2b_bytes_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
